// File: rtl/ex_pipe_ctrl.sv
// ID/EX and EX/MEM pipeline registers with load-use stall and EX-redirect flush control.
// Optional macro HAZ_COUNTERS_EN adds free-running stall/flush event counters.
module ex_pipe_ctrl #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] i_id_pc,
  input  logic [25:0]       i_id_jump_addr,
  input  logic [3:0]        i_id_op,
  input  logic [DWIDTH-1:0] i_id_imm,
  input  logic [DWIDTH-1:0] i_id_rs1,
  input  logic [DWIDTH-1:0] i_id_rs2,
  input  logic [4:0]        i_id_rs1_id,
  input  logic [4:0]        i_id_rs2_id,
  input  logic [4:0]        i_id_rdst_id,
  input  logic              i_id_we_reg,
  input  logic              i_id_we_dmem,
  input  logic              i_id_mem_read,
  input  logic [1:0]        i_id_wbsel,
  input  logic              i_id_ssel,
  input  logic [2:0]        i_id_jump_type,
  input  logic [DWIDTH-1:0] i_ex_alu_out,
  input  logic              i_ex_zero,
  output logic [DWIDTH-1:0] o_ex_pc,
  output logic [25:0]       o_ex_jump_addr,
  output logic [3:0]        o_ex_op,
  output logic [DWIDTH-1:0] o_ex_imm,
  output logic [DWIDTH-1:0] o_ex_rs1,
  output logic [DWIDTH-1:0] o_ex_rs2,
  output logic [4:0]        o_ex_rdst_id,
  output logic              o_ex_we_reg,
  output logic              o_ex_we_dmem,
  output logic              o_ex_mem_read,
  output logic [1:0]        o_ex_wbsel,
  output logic              o_ex_ssel,
  output logic [2:0]        o_ex_jump_type,
  output logic [DWIDTH-1:0] o_mem_pc,
  output logic [DWIDTH-1:0] o_mem_rd,
  output logic [DWIDTH-1:0] o_mem_rs2,
  output logic [4:0]        o_mem_rdst_id,
  output logic              o_mem_we_reg,
  output logic              o_mem_we_dmem,
  output logic [1:0]        o_mem_wbsel,
  output logic              o_ex_redirect,
  output logic              o_pc_write,
  output logic              o_ifid_write,
  output logic              o_ifid_flush
`ifdef HAZ_COUNTERS_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
`endif
);

  localparam logic [2:0] JT_BEQ = 3'd1;
  localparam logic [2:0] JT_JAL = 3'd2;
  localparam logic [2:0] JT_JR  = 3'd3;
  localparam logic [2:0] JT_J   = 3'd4;

  logic [DWIDTH-1:0] r_ex_pc, r_ex_imm, r_ex_rs1, r_ex_rs2;
  logic [25:0]       r_ex_jump_addr;
  logic [3:0]        r_ex_op;
  logic [4:0]        r_ex_rdst_id;
  logic              r_ex_we_reg, r_ex_we_dmem, r_ex_mem_read, r_ex_ssel;
  logic [1:0]        r_ex_wbsel;
  logic [2:0]        r_ex_jump_type;

  logic [DWIDTH-1:0] r_mem_pc, r_mem_rd, r_mem_rs2;
  logic [4:0]        r_mem_rdst_id;
  logic              r_mem_we_reg, r_mem_we_dmem;
  logic [1:0]        r_mem_wbsel;

  logic w_redirect, w_load_use, w_bubble, w_stall;

  // Hazard decode; reset forces free-running fetch so stale regs cannot stall or flush.
  always_comb begin
    w_redirect   = 1'b0;
    w_load_use   = 1'b0;
    w_bubble     = 1'b0;
    w_stall      = 1'b0;
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_ifid_flush = 1'b0;
    if (!rst) begin
      w_redirect = (r_ex_jump_type == JT_BEQ && i_ex_zero) ||
                   (r_ex_jump_type == JT_JAL) || (r_ex_jump_type == JT_JR) ||
                   (r_ex_jump_type == JT_J);
      w_load_use = r_ex_mem_read && (r_ex_rdst_id != 5'd0) &&
                   ((r_ex_rdst_id == i_id_rs1_id) || (r_ex_rdst_id == i_id_rs2_id));
      if (w_redirect) begin
        o_ifid_flush = 1'b1;
        w_bubble     = 1'b1;
      end else if (w_load_use) begin
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        w_bubble     = 1'b1;
        w_stall      = 1'b1;
      end
    end
  end

  assign o_ex_redirect = w_redirect;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_ex_pc        <= '0;
      r_ex_jump_addr <= '0;
      r_ex_op        <= '0;
      r_ex_imm       <= '0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rdst_id   <= '0;
      r_ex_we_reg    <= 1'b0;
      r_ex_we_dmem   <= 1'b0;
      r_ex_mem_read  <= 1'b0;
      r_ex_wbsel     <= '0;
      r_ex_ssel      <= 1'b0;
      r_ex_jump_type <= '0;
    end else begin
      r_ex_pc        <= i_id_pc;
      r_ex_jump_addr <= i_id_jump_addr;
      r_ex_op        <= i_id_op;
      r_ex_imm       <= i_id_imm;
      r_ex_rs1       <= i_id_rs1;
      r_ex_rs2       <= i_id_rs2;
      r_ex_rdst_id   <= i_id_rdst_id;
      r_ex_we_reg    <= i_id_we_reg;
      r_ex_we_dmem   <= i_id_we_dmem;
      r_ex_mem_read  <= i_id_mem_read;
      r_ex_wbsel     <= i_id_wbsel;
      r_ex_ssel      <= i_id_ssel;
      r_ex_jump_type <= i_id_jump_type;
    end
  end

  // EX/MEM is never flushed: a redirecting JAL must still commit its link value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_pc      <= '0;
      r_mem_rd      <= '0;
      r_mem_rs2     <= '0;
      r_mem_rdst_id <= '0;
      r_mem_we_reg  <= 1'b0;
      r_mem_we_dmem <= 1'b0;
      r_mem_wbsel   <= '0;
    end else begin
      r_mem_pc      <= r_ex_pc;
      r_mem_rd      <= i_ex_alu_out;
      r_mem_rs2     <= r_ex_rs2;
      r_mem_rdst_id <= r_ex_rdst_id;
      r_mem_we_reg  <= r_ex_we_reg;
      r_mem_we_dmem <= r_ex_we_dmem;
      r_mem_wbsel   <= r_ex_wbsel;
    end
  end

`ifdef HAZ_COUNTERS_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, w_stall};
      r_flush_cnt <= r_flush_cnt + {31'd0, w_redirect};
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

  assign o_ex_pc        = r_ex_pc;
  assign o_ex_jump_addr = r_ex_jump_addr;
  assign o_ex_op        = r_ex_op;
  assign o_ex_imm       = r_ex_imm;
  assign o_ex_rs1       = r_ex_rs1;
  assign o_ex_rs2       = r_ex_rs2;
  assign o_ex_rdst_id   = r_ex_rdst_id;
  assign o_ex_we_reg    = r_ex_we_reg;
  assign o_ex_we_dmem   = r_ex_we_dmem;
  assign o_ex_mem_read  = r_ex_mem_read;
  assign o_ex_wbsel     = r_ex_wbsel;
  assign o_ex_ssel      = r_ex_ssel;
  assign o_ex_jump_type = r_ex_jump_type;
  assign o_mem_pc       = r_mem_pc;
  assign o_mem_rd       = r_mem_rd;
  assign o_mem_rs2      = r_mem_rs2;
  assign o_mem_rdst_id  = r_mem_rdst_id;
  assign o_mem_we_reg   = r_mem_we_reg;
  assign o_mem_we_dmem  = r_mem_we_dmem;
  assign o_mem_wbsel    = r_mem_wbsel;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Randomized bench for ex_pipe_ctrl against a transaction-level model of the pipeline stages.
// Define HAZ_COUNTERS_EN to also check the stall/flush counters.
module tb_ex_pipe_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [25:0] jaddr;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rdst;
    logic        weReg;
    logic        weDmem;
    logic        memRead;
    logic [1:0]  wbsel;
    logic        ssel;
    logic [2:0]  jt;
  } stage_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd;
    logic [31:0] rs2;
    logic [4:0]  rdst;
    logic        weReg;
    logic        weDmem;
    logic [1:0]  wbsel;
  } memStage_t;

  logic clk = 1'b0;
  logic rst;
  stage_t idIn;
  logic [4:0] rs1Id, rs2Id;
  logic [31:0] aluOut;
  logic zero;

  logic [31:0] exPc, exImm, exRs1, exRs2, memPc, memRd, memRs2;
  logic [25:0] exJaddr;
  logic [3:0]  exOp;
  logic [4:0]  exRdst, memRdst;
  logic        exWeReg, exWeDmem, exMemRead, exSsel, memWeReg, memWeDmem;
  logic [1:0]  exWbsel, memWbsel;
  logic [2:0]  exJt;
  logic        exRedirect, pcWrite, ifidWrite, ifidFlush;
`ifdef HAZ_COUNTERS_EN
  logic [31:0] stallCnt, flushCnt;
`endif

  always #5 clk = ~clk;

  ex_pipe_ctrl #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_id_pc(idIn.pc), .i_id_jump_addr(idIn.jaddr), .i_id_op(idIn.op),
    .i_id_imm(idIn.imm), .i_id_rs1(idIn.rs1), .i_id_rs2(idIn.rs2),
    .i_id_rs1_id(rs1Id), .i_id_rs2_id(rs2Id), .i_id_rdst_id(idIn.rdst),
    .i_id_we_reg(idIn.weReg), .i_id_we_dmem(idIn.weDmem), .i_id_mem_read(idIn.memRead),
    .i_id_wbsel(idIn.wbsel), .i_id_ssel(idIn.ssel), .i_id_jump_type(idIn.jt),
    .i_ex_alu_out(aluOut), .i_ex_zero(zero),
    .o_ex_pc(exPc), .o_ex_jump_addr(exJaddr), .o_ex_op(exOp), .o_ex_imm(exImm),
    .o_ex_rs1(exRs1), .o_ex_rs2(exRs2), .o_ex_rdst_id(exRdst),
    .o_ex_we_reg(exWeReg), .o_ex_we_dmem(exWeDmem), .o_ex_mem_read(exMemRead),
    .o_ex_wbsel(exWbsel), .o_ex_ssel(exSsel), .o_ex_jump_type(exJt),
    .o_mem_pc(memPc), .o_mem_rd(memRd), .o_mem_rs2(memRs2), .o_mem_rdst_id(memRdst),
    .o_mem_we_reg(memWeReg), .o_mem_we_dmem(memWeDmem), .o_mem_wbsel(memWbsel),
    .o_ex_redirect(exRedirect), .o_pc_write(pcWrite),
    .o_ifid_write(ifidWrite), .o_ifid_flush(ifidFlush)
`ifdef HAZ_COUNTERS_EN
    , .o_stall_cnt(stallCnt), .o_flush_cnt(flushCnt)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  stage_t    exModel;
  memStage_t memModel;
  logic      modelValid = 1'b0;
  logic [31:0] stallModel, flushModel;
  logic      expRedirect, expLoadUse, expPcW, expIfW, expFlush;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected hazard behaviour from the current modelled EX contents and ID source ids.
  task automatic predictHazards();
    expRedirect = 1'b0;
    expLoadUse  = 1'b0;
    if (!rst) begin
      expRedirect = (exModel.jt == 3'd1) ? zero : (exModel.jt >= 3'd2 && exModel.jt <= 3'd4);
      expLoadUse  = exModel.memRead && exModel.rdst != 5'd0 &&
                    (exModel.rdst == rs1Id || exModel.rdst == rs2Id);
    end
    expPcW   = !(expLoadUse && !expRedirect);
    expIfW   = expPcW;
    expFlush = expRedirect;
  endtask

  task automatic sampleAndCheck();
    @(negedge clk);
    predictHazards();
    checkOutput("ex_redirect", exRedirect, expRedirect);
    checkOutput("pc_write", pcWrite, expPcW);
    checkOutput("ifid_write", ifidWrite, expIfW);
    checkOutput("ifid_flush", ifidFlush, expFlush);
    if (modelValid) begin
      checkOutput("ex_pc", exPc, exModel.pc);
      checkOutput("ex_jaddr_op", {exJaddr, exOp}, {exModel.jaddr, exModel.op});
      checkOutput("ex_imm", exImm, exModel.imm);
      checkOutput("ex_rs1_rs2", {exRs1, exRs2}, {exModel.rs1, exModel.rs2});
      checkOutput("ex_ctrl", {exRdst, exWeReg, exWeDmem, exMemRead, exWbsel, exSsel, exJt},
                  {exModel.rdst, exModel.weReg, exModel.weDmem, exModel.memRead,
                   exModel.wbsel, exModel.ssel, exModel.jt});
      checkOutput("mem_pc", memPc, memModel.pc);
      checkOutput("mem_rd", memRd, memModel.rd);
      checkOutput("mem_rs2", memRs2, memModel.rs2);
      checkOutput("mem_ctrl", {memRdst, memWeReg, memWeDmem, memWbsel},
                  {memModel.rdst, memModel.weReg, memModel.weDmem, memModel.wbsel});
`ifdef HAZ_COUNTERS_EN
      checkOutput("stall_cnt", stallCnt, stallModel);
      checkOutput("flush_cnt", flushCnt, flushModel);
`endif
    end
  endtask

  // Advance one clock: instruction in EX moves on, ID enters EX unless squashed.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      exModel    = '0;
      memModel   = '0;
      stallModel = '0;
      flushModel = '0;
      modelValid = 1'b1;
    end else begin
      memModel = '{pc: exModel.pc, rd: aluOut, rs2: exModel.rs2, rdst: exModel.rdst,
                   weReg: exModel.weReg, weDmem: exModel.weDmem, wbsel: exModel.wbsel};
      if (expRedirect) flushModel = flushModel + 32'd1;
      else if (expLoadUse) stallModel = stallModel + 32'd1;
      exModel = (expRedirect || expLoadUse) ? '0 : idIn;
    end
    #1;
  endtask

  task automatic applyStimulus();
    sampleAndCheck();
    advance();
  endtask

  task automatic setIdle();
    idIn = '0; rs1Id = '0; rs2Id = '0; aluOut = '0; zero = 1'b0; rst = 1'b0;
  endtask

  initial begin
    setIdle();
    idIn = '1;
    rst = 1'b1;
    applyStimulus();
    setIdle();
    sampleAndCheck();
    checkOutput("rst_ex_zero", {exPc, exOp, exJt, exWeReg}, 64'd0);
    checkOutput("rst_mem_zero", {memRd, memWbsel, memWeReg}, 64'd0);
    advance();

    // ALU op flows ID -> EX -> MEM
    idIn.op = 4'd2; idIn.rdst = 5'd5; idIn.weReg = 1'b1;
    applyStimulus();
    setIdle();
    aluOut = 32'h1234;
    sampleAndCheck();
    checkOutput("dir_ex_op", exOp, 4'd2);
    advance();
    sampleAndCheck();
    checkOutput("dir_mem_rd", memRd, 32'h1234);
    checkOutput("dir_mem_rdst", memRdst, 5'd5);
    advance();

    // Load-use stall, then same with rdst=0
    for (int r = 0; r < 2; r++) begin
      setIdle();
      idIn.memRead = 1'b1; idIn.weReg = 1'b1; idIn.wbsel = 2'b01;
      idIn.rdst = (r == 0) ? 5'd3 : 5'd0;
      applyStimulus();
      setIdle();
      rs1Id = (r == 0) ? 5'd3 : 5'd0;
      idIn.weReg = 1'b1; idIn.op = 4'd7;
      sampleAndCheck();
      checkOutput("dir_lu_pcw", pcWrite, (r == 0) ? 1'b0 : 1'b1);
      checkOutput("dir_lu_ifw", ifidWrite, (r == 0) ? 1'b0 : 1'b1);
      advance();
      sampleAndCheck();
      checkOutput("dir_lu_weReg", exWeReg, (r == 0) ? 1'b0 : 1'b1);
      advance();
    end

    // BEQ taken / not taken
    for (int z = 1; z >= 0; z--) begin
      setIdle();
      idIn.jt = 3'd1;
      applyStimulus();
      setIdle();
      zero = z[0];
      idIn.op = 4'd9;
      sampleAndCheck();
      checkOutput("dir_beq_redirect", exRedirect, z[0]);
      checkOutput("dir_beq_flush", ifidFlush, z[0]);
      advance();
      sampleAndCheck();
      checkOutput("dir_beq_ex_op", exOp, (z == 1) ? 4'd0 : 4'd9);
      advance();
    end

    // JAL in EX that also looks like a load-use: redirect wins, JAL commits
    setIdle();
    idIn.jt = 3'd2; idIn.memRead = 1'b1; idIn.rdst = 5'd4; idIn.weReg = 1'b1; idIn.wbsel = 2'b10;
    applyStimulus();
    setIdle();
    rs1Id = 5'd4;
    sampleAndCheck();
    checkOutput("dir_jal_pcw", pcWrite, 1'b1);
    checkOutput("dir_jal_flush", ifidFlush, 1'b1);
    advance();
    sampleAndCheck();
    checkOutput("dir_jal_wbsel", memWbsel, 2'b10);
    advance();

    // Randomized traffic with occasional mid-stream resets
    for (int n = 0; n < 600; n++) begin
      idIn.pc      = $urandom;
      idIn.jaddr   = 26'($urandom);
      idIn.op      = 4'($urandom_range(0, 15));
      idIn.imm     = $urandom;
      idIn.rs1     = $urandom;
      idIn.rs2     = $urandom;
      idIn.rdst    = 5'($urandom_range(0, 3));
      idIn.weReg   = 1'($urandom_range(0, 1));
      idIn.weDmem  = 1'($urandom_range(0, 1));
      idIn.memRead = ($urandom_range(0, 2) == 0);
      idIn.wbsel   = 2'($urandom_range(0, 3));
      idIn.ssel    = 1'($urandom_range(0, 1));
      idIn.jt      = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 7));
      rs1Id        = 5'($urandom_range(0, 3));
      rs2Id        = 5'($urandom_range(0, 3));
      aluOut       = $urandom;
      zero         = 1'($urandom_range(0, 1));
      rst          = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
